// File: rtl/mips_alu.sv
// Registered 32-bit MIPS-style ALU: result and zero flag captured one clock
// after operands/operation are presented; async active-low reset.
module mips_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] DataIn0,
    input  logic [WIDTH-1:0] DataIn1,
    output logic [WIDTH-1:0] DataOut,
    output logic             ZeroOut
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic [WIDTH-1:0] data_d, data_q;
    logic             zero_d, zero_q;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   diff_ext;

    // Sign-extended difference: low bits serve SUB, top bit is the exact signed less-than.
    always_comb begin
        shamt    = DataIn1[SHW-1:0];
        diff_ext = {DataIn0[WIDTH-1], DataIn0} - {DataIn1[WIDTH-1], DataIn1};
        data_d   = '0;
        case (ALUControl)
            OP_AND:  data_d = DataIn0 & DataIn1;
            OP_OR:   data_d = DataIn0 | DataIn1;
            OP_ADD:  data_d = DataIn0 + DataIn1;
            OP_XOR:  data_d = DataIn0 ^ DataIn1;
            OP_SUB:  data_d = diff_ext[WIDTH-1:0];
            OP_SLT:  data_d = WIDTH'(diff_ext[WIDTH]);
            OP_SLL:  data_d = DataIn0 << shamt;
            OP_SRL:  data_d = DataIn0 >> shamt;
            OP_SRA:  data_d = $unsigned($signed(DataIn0) >>> shamt);
            OP_SLTU: data_d = WIDTH'(DataIn0 < DataIn1);
            OP_NOR:  data_d = ~(DataIn0 | DataIn1);
            default: data_d = '0;
        endcase
        zero_d = (data_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            zero_q <= 1'b1;
        end else begin
            data_q <= data_d;
            zero_q <= zero_d;
        end
    end

    assign DataOut = data_q;
    assign ZeroOut = zero_q;

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: vector table plus random model vectors
// scored through an expected-result queue, and hand-written reset sequences.
module tb_mips_alu;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_ctrl;
    logic [31:0] din0;
    logic [31:0] din1;
    logic [31:0] dout;
    logic        zout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_zero;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp_data;
        logic        exp_zero;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    mips_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALUControl (alu_ctrl),
        .DataIn0    (din0),
        .DataIn1    (din1),
        .DataOut    (dout),
        .ZeroOut    (zout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got_d, input logic got_z,
                         input logic [31:0] exp_d, input logic exp_z);
        checks++;
        if (got_d !== exp_d || got_z !== exp_z) begin
            errors++;
            $display("FAIL %s: got data=%08h zero=%0b, expected data=%08h zero=%0b",
                     name, got_d, got_z, exp_d, exp_z);
        end
    endtask

    // Independent reference built from language operators.
    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a ^ b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: return a << sh;
            4'b1001: return a >> sh;
            4'b1010: return $unsigned($signed(a) >>> sh);
            4'b1011: return (a < b) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input string name, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ed, input logic ez,
                         input bit push);
        exp_t e;
        @(negedge clk);
        alu_ctrl = c;
        din0     = a;
        din1     = b;
        if (push) begin
            e.name     = name;
            e.exp_data = ed;
            e.exp_zero = ez;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: %0d results never appeared, expected 0 pending", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scoreboard monitor: one captured result per edge while out of reset.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, dout, zout, e.exp_data, e.exp_zero);
        end
    end

    initial begin
        vecs.push_back('{"add_1_2",      4'b0010, 32'h1,        32'h2,        32'h3,        1'b0});
        vecs.push_back('{"add_wrap",     4'b0010, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1});
        vecs.push_back('{"slt_1_2",      4'b0111, 32'h1,        32'h2,        32'h1,        1'b0});
        vecs.push_back('{"slt_4_2",      4'b0111, 32'h4,        32'h2,        32'h0,        1'b1});
        vecs.push_back('{"slt_neg1_1",   4'b0111, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0});
        vecs.push_back('{"slt_ovf",      4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h0,        1'b1});
        vecs.push_back('{"slt_ovf_rev",  4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'h1,        1'b0});
        vecs.push_back('{"sltu_ff_1",    4'b1011, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1});
        vecs.push_back('{"sltu_1_ff",    4'b1011, 32'h1,        32'hFFFFFFFF, 32'h1,        1'b0});
        vecs.push_back('{"sub_4_2",      4'b0110, 32'h4,        32'h2,        32'h2,        1'b0});
        vecs.push_back('{"beq_4_4",      4'b0110, 32'h4,        32'h4,        32'h0,        1'b1});
        vecs.push_back('{"sub_wrap",     4'b0110, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0});
        vecs.push_back('{"and",          4'b0000, 32'hF0F0000F, 32'h0FF00003, 32'h00F00003, 1'b0});
        vecs.push_back('{"or",           4'b0001, 32'hF0F0000F, 32'h0FF00003, 32'hFFF0000F, 1'b0});
        vecs.push_back('{"xor",          4'b0011, 32'hF0F0000F, 32'h0FF00003, 32'hFF00000C, 1'b0});
        vecs.push_back('{"nor",          4'b1100, 32'hF0F0000F, 32'h0FF00003, 32'h000FFFF0, 1'b0});
        vecs.push_back('{"sll",          4'b1000, 32'hF0F0000F, 32'h0FF00003, 32'h87800078, 1'b0});
        vecs.push_back('{"srl",          4'b1001, 32'hF0F0000F, 32'h0FF00003, 32'h1E1E0001, 1'b0});
        vecs.push_back('{"sra",          4'b1010, 32'hF0F0000F, 32'h0FF00003, 32'hFE1E0001, 1'b0});
        vecs.push_back('{"sll_sh0",      4'b1000, 32'hDEADBEEF, 32'hFFFFFFE0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{"sra_sh0",      4'b1010, 32'h80000001, 32'h00000020, 32'h80000001, 1'b0});
        vecs.push_back('{"sra_31",       4'b1010, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{"srl_31",       4'b1001, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0});
        vecs.push_back('{"illegal_f",    4'b1111, 32'h5,        32'h5,        32'h0,        1'b1});
        vecs.push_back('{"illegal_4",    4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b1});
        vecs.push_back('{"nor_zero",     4'b1100, 32'hFFFF0000, 32'h0000FFFF, 32'h0,        1'b1});

        // Reset held with nonzero operands
        rst_n    = 1'b0;
        alu_ctrl = 4'b0010;
        din0     = 32'h7;
        din1     = 32'h9;
        repeat (2) @(negedge clk);
        check("reset_hold", dout, zout, 32'h0, 1'b1);

        rst_n = 1'b1;
        drive("first_add_0_0", 4'b0010, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);

        for (int i = 0; i < vecs.size(); i++)
            drive(vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b,
                  vecs[i].exp_data, vecs[i].exp_zero, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  c;
            logic [31:0] a, b, r;
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = (i % 4 == 0) ? a : $urandom;
            r = ref_alu(c, a, b);
            drive("random", c, a, b, r, (r == 32'h0), 1'b1);
        end
        drain("drain_main");

        // Reset asserted between edges: outputs clear at once, pending capture dropped
        drive("pre_reset_add", 4'b0010, 32'h1, 32'h2, 32'h3, 1'b0, 1'b1);
        drive("pending_add", 4'b0010, 32'h5, 32'h6, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dout, zout, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        check("reset_discard", dout, zout, 32'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        drive("post_reset_sub", 4'b0110, 32'h9, 32'h4, 32'h5, 1'b0, 1'b1);
        drive("post_reset_beq", 4'b0110, 32'h9, 32'h9, 32'h0, 1'b1, 1'b1);
        drain("drain_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
